// File: rtl/regfile_pkg.sv
// Shared types and sizing for the 2-read / 1-write register file.
//   DATA_W    width of each register and of all data ports
//   NUM_REGS  number of architectural registers
//   ADDR_W    register index width
//   ZERO_REG  index that always reads zero and ignores writes
package regfile_pkg;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS);
    localparam int unsigned ZERO_REG = 31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg64_row.sv
// One enable-gated register row of the register file.
//   clk    rising-edge clock
//   reset  asynchronous active-high clear to zero
//   en     load strobe; the row holds its value when low
//   in     data loaded when en is high
//   out    current row contents
module reg64_row
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else if (en) begin
            out <= in;
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// 32 x 64-bit register file with one write port and two registered read ports.
// Register ZERO_REG reads as zero and discards writes. A read of the register
// being written on the same edge returns the new write data (bypass).
//   clk, reset             clock and asynchronous active-high reset
//   wr_en/wr_addr/wr_data  write port
//   rd_en_x/rd_addr_x      read request for port x (A or B)
//   rd_data_x              registered read data, held while rd_en_x is low
//   rd_valid_x             one-cycle pulse when rd_data_x carries a new result
module regfile_2r1w
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid_b
);

    localparam reg_addr_t ZeroAddr = reg_addr_t'(ZERO_REG);

    reg_data_t rows [NUM_REGS];
    reg_data_t val_a;
    reg_data_t val_b;

    // Storage rows. Each row's enable is one output of the write decoder,
    // qualified by wr_en. The zero register has no storage at all.
    for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_rows
        if (i == int'(ZERO_REG)) begin : g_zero
            assign rows[i] = '0;
        end else begin : g_row
            logic row_we;
            assign row_we = wr_en && (wr_addr == reg_addr_t'(i));

            reg64_row u_row (
                .clk   (clk),
                .reset (reset),
                .en    (row_we),
                .in    (wr_data),
                .out   (rows[i])
            );
        end
    end

    // Read muxes. Zero register wins over bypass so an in-flight write to it
    // can never leak out.
    always_comb begin
        val_a = rows[rd_addr_a];
        if (rd_addr_a == ZeroAddr) begin
            val_a = '0;
        end else if (wr_en && (wr_addr == rd_addr_a)) begin
            val_a = wr_data;
        end
    end

    always_comb begin
        val_b = rows[rd_addr_b];
        if (rd_addr_b == ZeroAddr) begin
            val_b = '0;
        end else if (wr_en && (wr_addr == rd_addr_b)) begin
            val_b = wr_data;
        end
    end

    // Output registers: data loads only on a request, valid pulses per request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_a  <= '0;
            rd_valid_a <= 1'b0;
            rd_data_b  <= '0;
            rd_valid_b <= 1'b0;
        end else begin
            rd_valid_a <= rd_en_a;
            rd_valid_b <= rd_en_b;
            if (rd_en_a) begin
                rd_data_a <= val_a;
            end
            if (rd_en_b) begin
                rd_data_b <= val_b;
            end
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rd_en_a;
    logic [4:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    logic        rd_valid_a;
    logic        rd_en_b;
    logic [4:0]  rd_addr_b;
    logic [63:0] rd_data_b;
    logic        rd_valid_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural register contents plus expected outputs.
    logic [63:0] model [32];
    logic [63:0] exp_data_a, exp_data_b;
    logic        exp_valid_a, exp_valid_b;

    regfile_2r1w dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en_a    (rd_en_a),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_valid_a (rd_valid_a),
        .rd_en_b    (rd_en_b),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .rd_valid_b (rd_valid_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_read(input logic [4:0] addr);
        if (addr == 5'd31) return 64'd0;
        if (wr_en && wr_addr == addr) return wr_data;
        return model[addr];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        exp_data_a  = 64'd0;
        exp_data_b  = 64'd0;
        exp_valid_a = 1'b0;
        exp_valid_b = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, " data_a"}, rd_data_a, exp_data_a);
        check_eq({tag, " valid_a"}, {63'd0, rd_valid_a}, {63'd0, exp_valid_a});
        check_eq({tag, " data_b"}, rd_data_b, exp_data_b);
        check_eq({tag, " valid_b"}, {63'd0, rd_valid_b}, {63'd0, exp_valid_b});
    endtask

    // Drive one cycle of stimulus (called 1 time unit after a posedge),
    // clock it, then compare against the model just after the edge.
    task automatic step(input string tag,
                        input bit we, input logic [4:0] wa, input logic [63:0] wd,
                        input bit ea, input logic [4:0] aa,
                        input bit eb, input logic [4:0] ab);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en_a = ea; rd_addr_a = aa;
        rd_en_b = eb; rd_addr_b = ab;
        if (ea) exp_data_a = ref_read(aa);
        if (eb) exp_data_b = ref_read(ab);
        exp_valid_a = ea;
        exp_valid_b = eb;
        @(posedge clk);
        if (we && wa != 5'd31) model[wa] = wd;
        #1;
        check_outputs(tag);
    endtask

    task automatic idle();
        step("idle", 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en_a = 1'b0; rd_addr_a = '0;
        rd_en_b = 1'b0; rd_addr_b = '0;
        clear_model();

        // Reset state
        @(posedge clk); #1;
        check_outputs("por");
        reset = 1'b0;
        idle();

        // Reset mid-read after writing X3=0xAA
        step("wr3", 1'b1, 5'd3, 64'hAA, 1'b1, 5'd3, 1'b0, 5'd0);
        check_eq("x3 bypass", rd_data_a, 64'hAA);
        wr_en = 1'b0;
        rd_en_a = 1'b1; rd_addr_a = 5'd3;
        rd_en_b = 1'b1; rd_addr_b = 5'd3;
        #3;
        reset = 1'b1;
        #1;
        clear_model();
        check_outputs("async rst");
        @(posedge clk); #1;
        check_outputs("rst drop read");
        reset = 1'b0;
        step("x3 after rst", 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 1'b1, 5'd3);
        check_eq("x3 cleared", rd_data_a, 64'd0);

        // Write then read
        step("wr5", 1'b1, 5'd5, 64'd9854768, 1'b0, 5'd0, 1'b0, 5'd0);
        step("rd5", 1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 1'b0, 5'd0);
        check_eq("x5 value", rd_data_a, 64'd9854768);
        idle();
        check_eq("x5 valid one cycle", {63'd0, rd_valid_a}, 64'd0);

        // Same-edge bypass on both ports
        step("byp7", 1'b1, 5'd7, 64'd550, 1'b1, 5'd7, 1'b1, 5'd7);
        check_eq("byp a", rd_data_a, 64'd550);
        check_eq("byp b", rd_data_b, 64'd550);

        // Zero register
        step("wr31", 1'b1, 5'd31, 64'd420, 1'b0, 5'd0, 1'b0, 5'd0);
        step("rd31", 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b1, 5'd31);
        check_eq("x31 read", rd_data_b, 64'd0);
        step("wrrd31", 1'b1, 5'd31, 64'd420, 1'b1, 5'd31, 1'b1, 5'd31);
        check_eq("x31 bypass a", rd_data_a, 64'd0);
        check_eq("x31 bypass b", rd_data_b, 64'd0);

        // Hold
        step("wr2", 1'b1, 5'd2, 64'd69, 1'b0, 5'd0, 1'b0, 5'd0);
        step("rd2", 1'b0, 5'd0, 64'd0, 1'b1, 5'd2, 1'b0, 5'd0);
        step("hold1", 1'b1, 5'd2, 64'd215687, 1'b0, 5'd2, 1'b0, 5'd0);
        step("hold2", 1'b0, 5'd0, 64'd0, 1'b0, 5'd2, 1'b0, 5'd0);
        step("hold3", 1'b0, 5'd0, 64'd0, 1'b0, 5'd2, 1'b0, 5'd0);
        check_eq("hold data", rd_data_a, 64'd69);
        step("reread2", 1'b0, 5'd0, 64'd0, 1'b1, 5'd2, 1'b0, 5'd0);
        check_eq("reread data", rd_data_a, 64'd215687);

        // Streaming
        for (int i = 0; i < 31; i++) begin
            step("fill", 1'b1, 5'(i), 64'(i * 3), 1'b0, 5'd0, 1'b0, 5'd0);
        end
        for (int i = 0; i < 31; i++) begin
            step("stream", 1'b0, 5'd0, 64'd0, 1'b1, 5'(i), 1'b1, 5'(30 - i));
            check_eq("stream a", rd_data_a, 64'(i * 3));
            check_eq("stream b", rd_data_b, 64'((30 - i) * 3));
        end

        // Randomized traffic, with read addresses biased towards the write address
        for (int n = 0; n < 400; n++) begin
            logic [4:0]  wa, aa, ab;
            logic [63:0] wd;
            wa = 5'($urandom_range(0, 31));
            wd = {$urandom, $urandom};
            aa = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ab = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            step("rand", 1'($urandom_range(0, 1)), wa, wd,
                 1'($urandom_range(0, 1)), aa, 1'($urandom_range(0, 1)), ab);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
